// File: rtl/i2s_tx.sv
// I2S master transmitter: double-buffers a signed L/R sample pair and shifts it out
// as BCLK/LRCK/SDATA, with BCLK and LRCK derived from clk.
// Define I2S_TX_LEFT_JUST_EN for left-justified timing (no one-BCLK data delay);
// the default build uses standard I2S timing.
module i2s_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_stb,
    input  logic [WIDTH-1:0] in_l,
    input  logic [WIDTH-1:0] in_r,
    output logic             i2s_bclk,
    output logic             i2s_lrck,
    output logic             i2s_data,
    output logic             frame_stb,
    output logic             underrun
);

    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SlotW  = (WIDTH > 1) ? $clog2(2 * WIDTH) : 1;
    localparam int unsigned FrameW = 2 * WIDTH;

    localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(FrameW - 1);
    localparam logic [SlotW-1:0] SlotHalf = SlotW'(WIDTH);

    logic [DivW-1:0]   div_q, div_d;
    logic              bclk_q, bclk_d;
    logic [SlotW-1:0]  slot_q, slot_d;
    logic              lrck_q, lrck_d;
    logic              data_q, data_d;
    logic              frame_stb_q, frame_stb_d;
    logic              underrun_q, underrun_d;
    logic [WIDTH-1:0]  hold_l_q, hold_l_d;
    logic [WIDTH-1:0]  hold_r_q, hold_r_d;
    logic              fresh_q, fresh_d;
    logic [FrameW-1:0] shift_q, shift_d;

    logic              tick;
    logic              fall;
    logic              load;
    logic [FrameW-1:0] next_frame;

    // Divider, slot sequencing, holding buffer and serializer next-state
    always_comb begin
        tick = (div_q == DivLast);
        fall = tick & bclk_q;
        load = fall & (slot_q == SlotLast);
        // A strobe landing on the load cycle bypasses the holding regs straight into the shifter
        next_frame = in_stb ? {in_l, in_r} : {hold_l_q, hold_r_q};

        div_d       = tick ? '0 : div_q + 1'b1;
        bclk_d      = tick ? ~bclk_q : bclk_q;
        slot_d      = slot_q;
        lrck_d      = lrck_q;
        data_d      = data_q;
        shift_d     = shift_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        fresh_d     = fresh_q;
        frame_stb_d = load;
        underrun_d  = load & ~fresh_q & ~in_stb;

        if (in_stb) begin
            hold_l_d = in_l;
            hold_r_d = in_r;
            fresh_d  = 1'b1;
        end
        if (load) begin
            fresh_d = 1'b0;
        end

        if (fall) begin
            slot_d = load ? '0 : slot_q + 1'b1;
            lrck_d = (slot_d >= SlotHalf);
            if (load) begin
`ifdef I2S_TX_LEFT_JUST_EN
                data_d  = next_frame[FrameW-1];
                shift_d = {next_frame[FrameW-2:0], 1'b0};
`else
                // Slot 0 still carries the previous right-word LSB
                data_d  = shift_q[FrameW-1];
                shift_d = next_frame;
`endif
            end else begin
                data_d  = shift_q[FrameW-1];
                shift_d = {shift_q[FrameW-2:0], 1'b0};
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            slot_q      <= '0;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            frame_stb_q <= 1'b0;
            underrun_q  <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            fresh_q     <= 1'b0;
            shift_q     <= '0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            slot_q      <= slot_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            frame_stb_q <= frame_stb_d;
            underrun_q  <= underrun_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            fresh_q     <= fresh_d;
            shift_q     <= shift_d;
        end
    end

    // Registered outputs
    always_comb begin
        i2s_bclk  = bclk_q;
        i2s_lrck  = lrck_q;
        i2s_data  = data_q;
        frame_stb = frame_stb_q;
        underrun  = underrun_q;
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx (CLK_DIV=2, WIDTH=16). Stimulus pushes the expected
// frame for each upcoming load; the monitor pops on frame_stb and checks underrun,
// frame/bclk periods, lrck per slot, data stability and the serial word bit-exact.
module tb_i2s_tx;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned WIDTH     = 16;
    localparam int unsigned FRAME_CLK = 2 * CLK_DIV * 2 * WIDTH;
`ifdef I2S_TX_LEFT_JUST_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic        und;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_stb;
    logic [15:0] in_l;
    logic [15:0] in_r;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_data;
    logic        frame_stb;
    logic        underrun;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    i2s_tx #(
        .CLK_DIV(CLK_DIV),
        .WIDTH  (WIDTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_stb   (in_stb),
        .in_l     (in_l),
        .in_r     (in_r),
        .i2s_bclk (i2s_bclk),
        .i2s_lrck (i2s_lrck),
        .i2s_data (i2s_data),
        .frame_stb(frame_stb),
        .underrun (underrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor state
    int          cyc = 0;
    int          idx;
    int          last_rise;
    int          last_stb;
    bit          have_rise;
    bit          have_stb;
    bit          cur_valid;
    bit          prev_valid;
    logic        bclk_prev;
    logic        data_prev;
    logic [31:0] bits;
    logic [31:0] prev_bits;
    exp_t        cur_exp;
    exp_t        prev_exp;
    exp_t        popped;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            idx        = 0;
            bits       = '0;
            prev_bits  = '0;
            cur_exp    = '0;
            prev_exp   = '0;
            cur_valid  = 1'b1;
            prev_valid = 1'b0;
            have_rise  = 1'b0;
            have_stb   = 1'b0;
            bclk_prev  = 1'b0;
            data_prev  = 1'b0;
        end else begin
            if (frame_stb) begin
                if (have_stb) check("frame_period", 64'(cyc - last_stb), 64'(FRAME_CLK));
                have_stb = 1'b1;
                last_stb = cyc;
                if (LJ && cur_valid) check("frame_data_lj", 64'(bits), {32'h0, cur_exp.l, cur_exp.r});
                prev_exp   = cur_exp;
                prev_bits  = bits;
                prev_valid = cur_valid;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: frame_stb with no expected entry at %0t", $time);
                    cur_valid = 1'b0;
                end else begin
                    popped = sb.pop_front();
                    check("underrun", 64'(underrun), 64'(popped.und));
                    cur_exp   = popped;
                    cur_valid = 1'b1;
                end
                bits = '0;
                idx  = 0;
            end
            if (i2s_bclk && !bclk_prev) begin
                if (have_rise) check("bclk_period", 64'(cyc - last_rise), 64'(2 * CLK_DIV));
                have_rise = 1'b1;
                last_rise = cyc;
                check("data_stable", 64'(i2s_data), 64'(data_prev));
                check("lrck", 64'(i2s_lrck), 64'(idx >= int'(WIDTH)));
                if (!LJ && idx == 0) begin
                    if (prev_valid)
                        check("frame_data", {32'h0, prev_bits[30:0], i2s_data},
                              {32'h0, prev_exp.l, prev_exp.r});
                end else begin
                    bits = {bits[30:0], i2s_data};
                end
                idx++;
            end
            bclk_prev = i2s_bclk;
            data_prev = i2s_data;
        end
    end

    task automatic push_exp(input logic [15:0] l, input logic [15:0] r, input logic u);
        exp_t e;
        e.l = l;
        e.r = r;
        e.und = u;
        sb.push_back(e);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        in_stb = 1'b1;
        in_l   = l;
        in_r   = r;
        @(negedge clk);
        in_stb = 1'b0;
    endtask

    task automatic wait_load();
        int n = 0;
        @(negedge clk);
        while (!frame_stb && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!frame_stb) begin
            total++;
            bad++;
            $display("FAIL load_timeout: frame_stb absent after %0d cycles, required within 400", n);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bclk"}, 64'(i2s_bclk), 64'd0);
        check({tag, "_lrck"}, 64'(i2s_lrck), 64'd0);
        check({tag, "_data"}, 64'(i2s_data), 64'd0);
        check({tag, "_frame_stb"}, 64'(frame_stb), 64'd0);
        check({tag, "_underrun"}, 64'(underrun), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        in_stb  = 1'b0;
        in_l    = '0;
        in_r    = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        #1 reset_n = 1'b1;

        // First frame after reset: zeros, underrun
        push_exp(16'h0000, 16'h0000, 1'b1);
        wait_load();

        // Mixed-sign sample
        repeat (20) @(negedge clk);
        push_exp(16'h8001, 16'h7FFE, 1'b0);
        send(16'h8001, 16'h7FFE);
        wait_load();

        // Two strobes in one frame: last wins
        repeat (10) @(negedge clk);
        send(16'h1111, 16'h2222);
        repeat (30) @(negedge clk);
        push_exp(16'h5A5A, 16'hC3C3, 1'b0);
        send(16'h5A5A, 16'hC3C3);
        wait_load();

        // Two starved frames replay the held sample
        push_exp(16'h5A5A, 16'hC3C3, 1'b1);
        wait_load();
        push_exp(16'h5A5A, 16'hC3C3, 1'b1);
        wait_load();

        // Strobe exactly on the load clock bypasses into the shifter
        repeat (FRAME_CLK - 1) @(negedge clk);
        push_exp(16'h1234, 16'hABCD, 1'b0);
        in_stb = 1'b1;
        in_l   = 16'h1234;
        in_r   = 16'hABCD;
        @(posedge clk);
        #1 in_stb = 1'b0;
        wait_load();

        repeat (10) @(negedge clk);
        push_exp(16'h0F0F, 16'hF0F0, 1'b0);
        send(16'h0F0F, 16'hF0F0);
        wait_load();

        // Reset in the middle of the right word
        repeat (80) @(negedge clk);
        check("sb_level_before_reset", 64'(sb.size()), 64'd0);
        #2 reset_n = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        push_exp(16'h0000, 16'h0000, 1'b1);
        wait_load();

        repeat (15) @(negedge clk);
        push_exp(16'h8000, 16'h0001, 1'b0);
        send(16'h8000, 16'h0001);
        wait_load();
        push_exp(16'h8000, 16'h0001, 1'b1);
        wait_load();

        repeat (12) @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
